shift_seq_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit D-flip-flop shift register datapath. It accepts a parallel word over a valid/ready handshake and shifts it out serially at a programmable bit rate, one bit per tick. On the same ticks it shifts serial input in, and presents the captured word over a second valid/ready handshake. It sits between a parallel producer/consumer and a serial link, and owns all timing of load, shift and capture.

---
 rtl/shift_seq_ctrl_pkg.sv | 14 +
 rtl/shift_seq_ctrl_if.sv | 23 ++
 rtl/shift_tick_gen.sv | 47 ++++
 rtl/shift_seq_ctrl.sv | 103 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared types and constants for the shift sequencing controller
package shift_seq_ctrl_pkg;

  // Controller states: wait for a word, serialise it, publish the captured word
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Level driven on the serial line when no word is in flight
  localparam logic IDLE_LVL = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - parallel tx/rx handshakes between producer/consumer and controller
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/shift_tick_gen.sv
// rtl/shift_tick_gen.sv - bit-period down-counter producing shift ticks
module shift_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,       // controller idle: hold counter at zero
  input  logic             load,      // word accepted: start first bit period
  input  logic [DIV_W-1:0] load_val,  // divider presented at accept
  input  logic             en,        // controller shifting
  input  logic [DIV_W-1:0] reload,    // divider frozen for the current word
  input  logic             stop,      // current tick is the last of the word
  output logic             tick,
  output logic             strobe     // registered copy of tick, aligned with it
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Count down to zero, reload on each tick; never wraps since zero always reloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? reload : cnt - DIV_W'(1);
    end
  end

  // Predict next cycle's tick so the strobe is a flop yet lines up with the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
    end else if (load) begin
      strobe <= (load_val == '0);
    end else if (en) begin
      strobe <= tick ? (!stop && (reload == '0)) : (cnt == DIV_W'(1));
    end else begin
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - load/shift/capture sequencing for the serial shift register
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus,
  input  logic [DIV_W-1:0] div,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             accept;
  logic             last;

  assign bus.tx_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = (state == IDLE) && bus.tx_valid;
  assign last         = tick && (bit_cnt == LAST_BIT);
  assign ser_out      = (state == IDLE) ? IDLE_LVL
                      : (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign shreg_next   = LSB_FIRST ? {ser_in, shreg[WIDTH-1:1]}
                                  : {shreg[WIDTH-2:0], ser_in};

  shift_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .load     (accept),
    .load_val (div),
    .en       (state == SHIFT),
    .reload   (div_q),
    .stop     (last),
    .tick     (tick),
    .strobe   (shift_en)
  );

  // Sequencer: load on accept, shift per tick, publish in DONE with overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_q        <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= bus.tx_data;
            div_q   <= div;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          bus.rx_data <= shreg;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A word published in DONE wins over a same-cycle consume
      if (state == DONE) begin
        bus.rx_valid <= 1'b1;
        overrun      <= bus.rx_valid && !bus.rx_ready;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - randomized self-checking bench for MSB-first and LSB-first controllers
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         rx_ready = 1'b0;
  logic [7:0]   div = '0;
  logic         ser_rnd = 1'b0;
  logic         loop = 1'b1;

  logic ser_out_m, ser_out_l, shift_en_m, shift_en_l;
  logic busy_m, busy_l, ovr_m, ovr_l;

  int total = 0;
  int bad = 0;

  // Reference rx-side state shared by both controllers (same handshakes, same timing)
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic [W-1:0] m_dm = '0;
  logic [W-1:0] m_dl = '0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(W)) bus_m ();
  shift_seq_ctrl_if #(.WIDTH(W)) bus_l ();

  assign bus_m.tx_data  = tx_data;
  assign bus_m.tx_valid = tx_valid;
  assign bus_m.rx_ready = rx_ready;
  assign bus_l.tx_data  = tx_data;
  assign bus_l.tx_valid = tx_valid;
  assign bus_l.rx_ready = rx_ready;

  shift_seq_ctrl #(.WIDTH(W), .DIV_W(8), .LSB_FIRST(1'b0)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_m),
    .div      (div),
    .ser_out  (ser_out_m),
    .ser_in   (loop ? ser_out_m : ser_rnd),
    .shift_en (shift_en_m),
    .busy     (busy_m),
    .overrun  (ovr_m)
  );

  shift_seq_ctrl #(.WIDTH(W), .DIV_W(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_l),
    .div      (div),
    .ser_out  (ser_out_l),
    .ser_in   (loop ? ser_out_l : ser_rnd),
    .shift_en (shift_en_l),
    .busy     (busy_l),
    .overrun  (ovr_l)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge of consumer activity to the reference rx state
  task automatic model_rx(input logic r, input logic done, input logic [W-1:0] wm, input logic [W-1:0] wl);
    if (done) begin
      m_ovr   = m_valid & ~r;
      m_valid = 1'b1;
      m_dm    = wm;
      m_dl    = wl;
    end else begin
      m_ovr = 1'b0;
      if (m_valid && r) m_valid = 1'b0;
    end
  endtask

  task automatic rx_checks();
    check_val("rx_valid_m", bus_m.rx_valid, m_valid);
    check_val("rx_valid_l", bus_l.rx_valid, m_valid);
    check_val("rx_data_m", bus_m.rx_data, m_dm);
    check_val("rx_data_l", bus_l.rx_data, m_dl);
    check_val("overrun_m", ovr_m, m_ovr);
    check_val("overrun_l", ovr_l, m_ovr);
  endtask

  task automatic idle_checks();
    check_val("idle_tx_ready_m", bus_m.tx_ready, 1);
    check_val("idle_tx_ready_l", bus_l.tx_ready, 1);
    check_val("idle_busy_m", busy_m, 0);
    check_val("idle_busy_l", busy_l, 0);
    check_val("idle_shift_en_m", shift_en_m, 0);
    check_val("idle_shift_en_l", shift_en_l, 0);
    check_val("idle_ser_out_m", ser_out_m, 1);
    check_val("idle_ser_out_l", ser_out_l, 1);
    rx_checks();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_ser_out_m", ser_out_m, 1);
    check_val("rst_ser_out_l", ser_out_l, 1);
    check_val("rst_rx_valid_m", bus_m.rx_valid, 0);
    check_val("rst_rx_valid_l", bus_l.rx_valid, 0);
    check_val("rst_busy_m", busy_m, 0);
    check_val("rst_busy_l", busy_l, 0);
    check_val("rst_shift_en_m", shift_en_m, 0);
    check_val("rst_shift_en_l", shift_en_l, 0);
    check_val("rst_overrun_m", ovr_m, 0);
    check_val("rst_overrun_l", ovr_l, 0);
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_dm     = '0;
    m_dl     = '0;
    tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_checks();
      tx_valid = 1'b0;
      ser_rnd  = 1'($urandom);
      rx_ready = rdy;
      model_rx(rdy, 1'b0, '0, '0);
    end
  endtask

  // One word: accept in the current IDLE cycle, W*(d+1) SHIFT cycles, one DONE cycle.
  // Bit b is on the line during cycles b*(d+1) .. b*(d+1)+d; the last of those is the tick.
  task automatic send_word(input logic [W-1:0] data, input logic [7:0] d, input bit lp,
                           input bit rnd_rdy, input logic rdy_done, input int abort_bit);
    int p;
    int b;
    logic r;
    logic [W-1:0] em;
    logic [W-1:0] el;
    p  = int'(d) + 1;
    em = '0;
    el = '0;
    @(negedge clk);
    idle_checks();
    loop     = lp;
    tx_valid = 1'b1;
    tx_data  = data;
    div      = d;
    ser_rnd  = 1'($urandom);
    r        = rnd_rdy ? 1'($urandom) : 1'b0;
    rx_ready = r;
    model_rx(r, 1'b0, '0, '0);
    for (int k = 0; k < W * p; k++) begin
      @(negedge clk);
      if (k == abort_bit * p) begin
        do_reset();
        return;
      end
      b = k / p;
      check_val("ser_out_m", ser_out_m, data[W-1-b]);
      check_val("ser_out_l", ser_out_l, data[b]);
      check_val("shift_en_m", shift_en_m, (k % p) == (p - 1));
      check_val("shift_en_l", shift_en_l, (k % p) == (p - 1));
      check_val("busy_m", busy_m, 1);
      check_val("busy_l", busy_l, 1);
      check_val("tx_ready_m", bus_m.tx_ready, 0);
      check_val("tx_ready_l", bus_l.tx_ready, 0);
      rx_checks();
      // Producer noise while busy: must not be accepted nor disturb timing/data
      tx_valid = 1'($urandom);
      tx_data  = W'($urandom);
      div      = 8'($urandom);
      ser_rnd  = 1'($urandom);
      if ((k % p) == (p - 1)) begin
        em[W-1-b] = lp ? data[W-1-b] : ser_rnd;
        el[b]     = lp ? data[b] : ser_rnd;
      end
      r        = rnd_rdy ? 1'($urandom) : 1'b0;
      rx_ready = r;
      model_rx(r, 1'b0, '0, '0);
    end
    @(negedge clk);
    check_val("done_busy_m", busy_m, 1);
    check_val("done_busy_l", busy_l, 1);
    check_val("done_shift_en_m", shift_en_m, 0);
    check_val("done_shift_en_l", shift_en_l, 0);
    check_val("done_tx_ready_m", bus_m.tx_ready, 0);
    check_val("done_ser_out_m", ser_out_m, em[W-1]);
    check_val("done_ser_out_l", ser_out_l, el[0]);
    rx_checks();
    tx_valid = 1'($urandom);
    tx_data  = W'($urandom);
    rx_ready = rdy_done;
    model_rx(rdy_done, 1'b1, em, el);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1, 1'b0);
    do_reset();

    // Directed cases
    send_word(8'hA5, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    send_word(8'h81, 8'd3, 1'b1, 1'b0, 1'b1, -1);
    idle_cycles(2, 1'b1);
    send_word(8'h3C, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    send_word(8'hC3, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    idle_cycles(2, 1'b0);
    send_word(8'h3C, 8'd2, 1'b1, 1'b0, 1'b0, -1);
    send_word(8'hC3, 8'd1, 1'b1, 1'b0, 1'b1, -1);
    idle_cycles(1, 1'b1);
    send_word(8'h77, 8'd0, 1'b1, 1'b0, 1'b0, 4);
    send_word(8'hE1, 8'd2, 1'b0, 1'b1, 1'b0, 4);
    send_word(8'h5A, 8'd0, 1'b1, 1'b0, 1'b0, -1);
    send_word(W'($urandom), 8'hFF, 1'b0, 1'b1, 1'($urandom), -1);

    // Randomized words, rates, serial input, consumer behaviour and aborts
    for (int i = 0; i < 30; i++) begin
      send_word(W'($urandom), 8'($urandom_range(0, 6)), 1'($urandom), 1'b1, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), 1'($urandom));
    end
    idle_cycles(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
